// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer scanout path: default geometry and
// bus widths, the RGB555 pixel layout, the stream tag bundle and the scanout
// FSM state encoding.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_DATA_W = 15;
  localparam int FB_ADDR_W = 16;
  localparam int FB_H      = 240;
  localparam int FB_V      = 160;

  // RGB555 pixel as stored in the frame buffer.
  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } pixel_t;

  // Stream markers travelling alongside each pixel word.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } scan_state_t;

endpackage

// File: rtl/fb_skid_fifo.sv
// -----------------------------------------------------------------------------
// fb_skid_fifo
// Two-entry FIFO holding pixel words plus their sof/eol/eof tags. It absorbs
// the one read already in flight when the stream stalls.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write push_data_i/push_tag_i this cycle
//   pop_i         consume the head entry (ignored when empty)
//   head_data_o   head pixel word
//   head_tag_o    head tags
//   valid_o       FIFO not empty
//   count_o       number of stored entries (0..2)
// -----------------------------------------------------------------------------
module fb_skid_fifo
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  pix_tag_t              push_tag_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output pix_tag_t              head_tag_o,
  output logic                  valid_o,
  output logic [1:0]            count_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    pix_tag_t              tag;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is only two entries and is reset so the stream data
      // reads 0 out of reset; a deep RAM-based FIFO would leave it unreset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every update here based on the
      // values from before the edge, so push and pop can share a cycle.
      // When full, wr_ptr_q equals rd_ptr_q: a push with a pop overwrites the
      // head slot that is leaving this very edge.
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{data: push_data_i, tag: push_tag_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(do_pop);
    end
  end

  assign head_data_o = mem_q[rd_ptr_q].data;
  assign head_tag_o  = mem_q[rd_ptr_q].tag;
  assign valid_o     = (count_q != 2'd0);
  assign count_o     = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (count_q == 2'd2) && !pop_i))
    else $error("fb_skid_fifo: push into a full FIFO without a pop");

endmodule

// File: rtl/fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// fb_scanout_reader
// Read-side master for the frame-buffer RAM (registered read port, 1-cycle
// latency). On start it walks the frame in raster order, issues read_addr and
// presents the returned words as a valid/ready pixel stream with sof/eol/eof.
// Reads are credit-limited against a 2-entry skid FIFO, so a stalled stream
// never loses a word already requested from the RAM.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         1-cycle pulse, starts a frame scan when idle
//   busy          frame scan in progress
//   read_addr     RAM read address
//   q             RAM read data (valid 1 cycle after read_addr)
//   pix_data      pixel word
//   pix_valid     stream valid
//   pix_ready     stream ready
//   pix_sof       first pixel of the frame
//   pix_eol       last pixel of a line
//   pix_eof       last pixel of the frame
//   swap_req      (FB_SCANOUT_DOUBLE_BUF_EN) sticky bank-swap request
//   disp_bank     (FB_SCANOUT_DOUBLE_BUF_EN) bank being displayed, drives MSB
//
// Build option: define FB_SCANOUT_DOUBLE_BUF_EN for double buffering.
// -----------------------------------------------------------------------------
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_W,
  parameter int ADDR_WIDTH = FB_ADDR_W,
  parameter int H_PIXELS   = FB_H,
  parameter int V_LINES    = FB_V,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  ,
  input  logic                  swap_req,
  output logic                  disp_bank
`endif
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]         X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]         Y_LAST = YW'(V_LINES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);

  scan_state_t           state_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  inflight_q;
  pix_tag_t              inflight_tag_q;

  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  pix_tag_t              head_tag;
  logic                  pop;
  logic                  issue;
  logic                  x_last;
  logic                  start_ok;
  pix_tag_t              issue_tag;

  assign pop      = fifo_valid && pix_ready;
  assign start_ok = start && (state_q == IDLE);
  assign x_last   = (x_q == X_LAST);

  // Credit: words stored plus the word in flight, less the one leaving now,
  // must stay below the FIFO depth for another read to be issued.
  assign issue = (state_q == FETCH) &&
                 (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign issue_tag.sof = (x_q == '0) && (y_q == '0);
  assign issue_tag.eol = x_last;
  assign issue_tag.eof = x_last && (y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      addr_q         <= BASE;
      busy_q         <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      // The word requested this cycle returns on q during the next one.
      inflight_q     <= issue;
      inflight_tag_q <= issue ? issue_tag : '0;

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= BASE;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (issue_tag.eof) begin
              // Last address stays on read_addr.
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              if (x_last) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
          end
        end
        DRAIN: begin
          // The eof word is the last one requested, so its transfer leaves the
          // FIFO empty with nothing in flight.
          if (pop && head_tag.eof) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fb_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (q),
    .push_tag_i  (inflight_tag_q),
    .pop_i       (pop),
    .head_data_o (pix_data),
    .head_tag_o  (head_tag),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign busy      = busy_q;
  assign pix_valid = fifo_valid;
  assign pix_sof   = fifo_valid && head_tag.sof;
  assign pix_eol   = fifo_valid && head_tag.eol;
  assign pix_eof   = fifo_valid && head_tag.eof;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  logic bank_q;
  logic swap_pend_q;
  logic unused_addr_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (start_ok) begin
      // A request arriving together with start is honoured immediately.
      if (swap_pend_q || swap_req) begin
        bank_q <= ~bank_q;
      end
      swap_pend_q <= 1'b0;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end

  // The bank replaces the counter MSB, so the scan wraps within one bank.
  assign unused_addr_msb = addr_q[ADDR_WIDTH-1];
  assign read_addr       = {bank_q, addr_q[ADDR_WIDTH-2:0]};
  assign disp_bank       = bank_q;
`else
  assign read_addr = addr_q;
`endif

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Read-side master for the dual-port frame-buffer RAM (one registered read port, 1-cycle read latency).
- On a start pulse, it walks the frame in raster order (H_PIXELS x V_LINES of RGB555 words) and issues `read_addr`.
- It captures `q` and presents the pixels as a valid/ready stream with start-of-frame and end-of-line markers for the downstream video/scaler path.
- Back-pressure is absorbed by a 2-entry skid FIFO, so no read is ever lost to the RAM's fixed latency.

Parameters:
- DATA_WIDTH, 15, pixel word width; matches RAM data width.
- ADDR_WIDTH, 16, RAM address width.
- H_PIXELS, 240, pixels per line.
- V_LINES, 160, lines per frame; H_PIXELS*V_LINES must be <= 2**ADDR_WIDTH (2**(ADDR_WIDTH-1) with the optional feature).
- BASE_ADDR, 0, word address of pixel (0,0).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins one frame scan (ignored unless IDLE).
- busy  out  1  high from the cycle after an accepted start until the last pixel is accepted downstream.
- read_addr  out  ADDR_WIDTH  RAM read address.
- q  in  DATA_WIDTH  RAM read data, valid 1 cycle after read_addr (registered port).
- pix_data  out  DATA_WIDTH  pixel word.
- pix_valid  out  1  stream valid.
- pix_ready  in  1  stream ready.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_eol  out  1  qualifies the last pixel of each line.
- pix_eof  out  1  qualifies the last pixel of the frame.

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=IDLE; busy=0, pix_valid=0, pix_sof/eol/eof=0, pix_data=0, read_addr=BASE_ADDR; FIFO empty; counters 0; in-flight flag 0.
- States:
  - IDLE: on `start`, load x=0, y=0, addr=BASE_ADDR, go to FETCH.
  - FETCH: issue reads while credit allows; after issuing the last address, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to IDLE.
- Credit rule: a read issues in a cycle iff (fifo_count + inflight − pop_this_cycle) < 2. The issued address is held on read_addr. `inflight` is set in the cycle after an issue, and data is pushed to the FIFO the following edge with its sof/eol/eof tags. The FIFO can never overflow; overflow is an assertion failure.
- Throughput: with pix_ready held high, 1 pixel/clk sustained. The first pix_valid rises 2 cycles after `start` is sampled.
- Stream rules:
  - pix_valid, once high, stays high with stable data/tags until pix_valid & pix_ready.
  - A transfer occurs on pix_valid & pix_ready.
  - Simultaneous push and pop on a full FIFO is legal.
- Counters:
  - x wraps H_PIXELS−1 → 0 and increments y.
  - Frame ends at x=H_PIXELS−1, y=V_LINES−1.
  - addr increments by 1 and wraps modulo 2**ADDR_WIDTH.
  - Tags are computed from x/y at issue time.
- `start` while busy: ignored, no restart.
- Reset mid-frame: immediate return to the reset state; a pending RAM read is discarded.
- busy falls in the cycle after the pix_eof transfer.

Optional Feature:
- FB_SCANOUT_DOUBLE_BUF_EN: adds input `swap_req` (1 bit) and output `disp_bank` (1 bit, reset 0).
  - `swap_req` is a sticky request; it is latched any cycle.
  - At each accepted `start`, a pending request toggles disp_bank and clears the request.
  - read_addr MSB = disp_bank; lower bits are the scan address.
- Without the macro: no extra ports, and the full address comes from the counter.

Decomposition:
- Shared package fb_pkg:
  - FB_DATA_W=15, FB_ADDR_W=16, FB_H=240, FB_V=160.
  - A pixel typedef (RGB555 struct).
  - Scanout state enum {IDLE, FETCH, DRAIN}.
- One natural sub-module: fb_skid_fifo, a 2-entry FIFO carrying {data, sof, eol, eof} with a count output.

Test Plan:
- Full frame, ready always 1, RAM preloaded with addr[14:0]:
  - 38400 pixels in order, one per clk after a 2-cycle start latency.
  - sof on pixel 0 only; eol every 240th; eof on pixel 38399.
  - busy falls 1 cycle later.
- Random back-pressure (ready 30% duty), H=4, V=3:
  - Data sequence identical to the free-running run.
  - valid/data stable while stalled; no FIFO overflow assertion.
- `start` pulsed again mid-frame and on the busy falling edge:
  - Mid-frame pulse ignored.
  - Pulse sampled in IDLE restarts at BASE_ADDR.
- rst_n asserted at pixel 100 with ready=0:
  - All outputs return to reset values asynchronously.
  - A new start emits pixel 0 with sof.
- BASE_ADDR=65530, H=4, V=3:
  - read_addr wraps 65535 → 0.
  - Pixels match RAM words 65530..5.
- FB_SCANOUT_DOUBLE_BUF_EN, swap_req pulsed during frame 0:
  - Frame 1 reads with MSB=1 and disp_bank=1.
  - Frame 2 (no request) keeps bank 1.
